// File: rtl/crc_rx_checker.sv
// crc_rx_checker
//   Receive-side checker for the 16-bit-data / 9-bit-CRC code. Collects a
//   25-bit codeword serially (data[15] first, crc[0] last), recomputes the
//   CRC over the received data and presents the result on a valid/ready
//   output. Keeps a saturating count of frames that failed the check.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_bit          serial codeword bit
//   in_valid        in_bit valid this cycle
//   in_sof          first bit of a frame (qualified by in_valid)
//   in_ready        block accepts a bit this cycle
//   out_data        received data word
//   out_crc_rx      received CRC field
//   out_crc_calc    CRC recomputed from out_data
//   out_crc_err     out_crc_rx != out_crc_calc
//   out_valid       output word valid
//   out_ready       consumer accepts the output word
//   err_count       saturating count of frames with a CRC error
module crc_rx_checker (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_bit,
  input  logic        in_valid,
  input  logic        in_sof,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic [8:0]  out_crc_rx,
  output logic [8:0]  out_crc_calc,
  output logic        out_crc_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, HOLD} state_t;

  state_t      state, state_nxt;
  logic [24:0] sr;
  logic [4:0]  cnt;
  logic        xfer;
  logic [15:0] rx_data;
  logic [8:0]  rx_crc;
  logic [8:0]  crc_calc;

  // Same equations as the transmit-side generator.
  function automatic logic [8:0] crc9(input logic [15:0] d);
    logic [8:0] c;
    c[0] = d[0]^d[1]^d[2]^d[3]^d[12]^d[13]^d[14]^d[15];
    c[1] = d[0]^d[4]^d[12];
    c[2] = d[1]^d[5]^d[13];
    c[3] = d[2]^d[6]^d[14];
    c[4] = d[0]^d[1]^d[2]^d[7]^d[12]^d[13]^d[14];
    c[5] = d[0]^d[8]^d[12];
    c[6] = d[1]^d[9]^d[13];
    c[7] = d[2]^d[10]^d[14];
    c[8] = d[0]^d[1]^d[2]^d[11]^d[12]^d[13]^d[14];
    return c;
  endfunction

  assign xfer     = in_valid & in_ready;
  // First bit shifted in ends up in the MSB after 25 shifts.
  assign rx_data  = sr[24:9];
  assign rx_crc   = sr[8:0];
  assign crc_calc = crc9(rx_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (xfer && in_sof) state_nxt = SHIFT;
      end
      SHIFT: begin
        in_ready = 1'b1;
        // An SOF here restarts the frame, so it never completes one.
        if (xfer && !in_sof && cnt == 5'd24) state_nxt = CHECK;
      end
      CHECK: state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Deserializer: SOF always (re)loads; plain bits only count inside a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (xfer) begin
      if (in_sof) begin
        sr  <= {24'd0, in_bit};
        cnt <= 5'd1;
      end else if (state == SHIFT) begin
        sr  <= {sr[23:0], in_bit};
        cnt <= cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data     <= '0;
      out_crc_rx   <= '0;
      out_crc_calc <= '0;
      out_crc_err  <= 1'b0;
      err_count    <= '0;
    end else if (state == CHECK) begin
      out_data     <= rx_data;
      out_crc_rx   <= rx_crc;
      out_crc_calc <= crc_calc;
      out_crc_err  <= (rx_crc != crc_calc);
      if (rx_crc != crc_calc && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_crc_rx_checker.sv
// Self-checking bench for crc_rx_checker: directed frames from the test plan
// plus randomized frames/gaps, checked against a mask-table CRC reference.
module tb_crc_rx_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_bit = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic [8:0]  out_crc_rx, out_crc_calc;
  logic        out_crc_err, out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  err_count;

  crc_rx_checker dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .out_data(out_data), .out_crc_rx(out_crc_rx),
    .out_crc_calc(out_crc_calc), .out_crc_err(out_crc_err), .out_valid(out_valid),
    .out_ready(out_ready), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int exp_frames = 0, n_vld = 0;
  int errs = 0;
  logic pv = 1'b0;

  // Count distinct output words presented.
  always @(negedge clk) begin
    if (out_valid && !pv) n_vld++;
    pv = out_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each CRC bit is the parity of the data bits selected by a tap mask.
  function automatic logic [8:0] ref_crc(input logic [15:0] d);
    logic [15:0] m;
    logic [8:0]  c;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: m = 16'hF00F;
        1: m = 16'h1011;
        2: m = 16'h2022;
        3: m = 16'h4044;
        4: m = 16'h7087;
        5: m = 16'h1101;
        6: m = 16'h2202;
        7: m = 16'h4404;
        default: m = 16'h7807;
      endcase
      c[i] = ^(d & m);
    end
    return c;
  endfunction

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic send_bit(input logic b, input logic sof, input int maxgap);
    int g, n;
    logic rdy;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    in_valid = 1'b0;
    repeat (g) begin
      in_bit = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_bit = b; in_sof = sof;
    n = 0;
    forever begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] d, input logic [8:0] c, input int nbits, input int maxgap);
    logic [24:0] w;
    w = {d, c};
    for (int i = 0; i < nbits; i++) send_bit(w[24-i], (i == 0), maxgap);
  endtask

  // Called right after the last bit transfer; checks exact latency and the word.
  task automatic wait_out(input logic [15:0] d, input logic [8:0] c, input int hold);
    logic [8:0] calc;
    logic       err;
    calc = ref_crc(d);
    err  = (calc != c);
    if (err && errs < 255) errs++;
    exp_frames++;
    @(negedge clk);
    chk("vld_in_check", 32'(out_valid), 32'd0);
    chk("rdy_in_check", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("vld_latency", 32'(out_valid), 32'd1);
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) @(negedge clk);
      chk("data", 32'(out_data), 32'(d));
      chk("crc_rx", 32'(out_crc_rx), 32'(c));
      chk("crc_calc", 32'(out_crc_calc), 32'(calc));
      chk("crc_err", 32'(out_crc_err), 32'(err));
      chk("err_count", 32'(err_count), 32'(errs));
      chk("rdy_in_hold", 32'(in_ready), 32'd0);
      chk("vld_in_hold", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic frame(input logic [15:0] d, input logic [8:0] c, input int maxgap, input int hold);
    send_bits(d, c, 25, maxgap);
    wait_out(d, c, hold);
  endtask

  initial begin
    logic [15:0] d;
    logic [8:0]  c;
    #3;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Directed frames.
    frame(16'h0001, 9'h133, 0, 0);
    frame(16'hFFFF, 9'h1FE, 0, 0);
    frame(16'h0010, 9'h003, 0, 0);
    chk("errcnt_after_bad", 32'(err_count), 32'd1);

    // Random frames, random gaps, consumer stalls 10 cycles; some discarded
    // non-SOF bits in IDLE before a frame.
    for (int f = 0; f < 20; f++) begin
      d = 16'($urandom);
      c = ref_crc(d);
      if ($urandom_range(1, 0) == 1) c = c ^ 9'($urandom_range(511, 1));
      if (f % 3 == 0) begin
        send_bit(1'($urandom), 1'b0, 2);
        send_bit(1'($urandom), 1'b0, 2);
      end
      frame(d, c, (f % 2 == 0) ? 3 : 0, 10);
    end
    chk("frames_rand", 32'(n_vld), 32'(exp_frames));

    // SOF after 10 bits restarts; only the clean zero frame is output.
    d = 16'($urandom);
    send_bits(d, ref_crc(d) ^ 9'h1, 10, 1);
    frame(16'h0000, 9'h000, 1, 2);
    chk("frames_restart", 32'(n_vld), 32'(exp_frames));

    // Reset after 20 bits: outputs at reset values, no spurious word.
    d = 16'($urandom);
    send_bits(d, ref_crc(d), 20, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_crc", 32'({out_crc_rx, out_crc_calc, out_crc_err}), 32'd0);
    chk("mid_rst_errcnt", 32'(err_count), 32'd0);
    errs = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    chk("frames_after_rst", 32'(n_vld), 32'(exp_frames));
    d = 16'($urandom);
    frame(d, ref_crc(d), 0, 1);

    // Saturation.
    for (int f = 0; f < 260; f++) begin
      d = 16'($urandom);
      frame(d, ref_crc(d) ^ 9'h001, 0, 0);
    end
    chk("errcnt_sat", 32'(err_count), 32'd255);
    repeat (3) begin @(posedge clk); #1; end
    chk("errcnt_sat_hold", 32'(err_count), 32'd255);
    chk("frames_total", 32'(n_vld), 32'(exp_frames));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/crc_rx_checker.md
# crc_rx_checker

Receive-side counterpart of the team's 16-bit-data / 9-bit-CRC generator. Deserializes a 25-bit codeword (16 data bits followed by 9 CRC bits) arriving one bit per accepted transfer. It then recomputes the CRC over the received data with the generator's equations and presents data, received CRC, computed CRC and an error flag on a valid/ready output. It sits between the serial link front-end and the word-level consumer, and keeps a saturating count of failed frames.

## Interface
- No parameters; widths are fixed by the CRC definition (16 data, 9 CRC).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_bit  in  1  serial codeword bit.
- in_valid  in  1  in_bit is valid this cycle.
- in_sof  in  1  qualifies the first bit of a frame; only meaningful with in_valid.
- in_ready  out  1  block accepts a bit this cycle; transfer = in_valid & in_ready.
- out_data  out  16  received data word.
- out_crc_rx  out  9  received CRC field.
- out_crc_calc  out  9  CRC recomputed from out_data.
- out_crc_err  out  1  out_crc_rx != out_crc_calc.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts; transfer = out_valid & out_ready.
- err_count  out  8  saturating count of frames with crc_err.

## Operation
- Bit order: data[15] first through data[0], then crc[8] through crc[0]; 25 transfers per frame.
- CRC equations (c = computed, d = data):
  - c0 = d0^d1^d2^d3^d12^d13^d14^d15
  - c1 = d0^d4^d12; c2 = d1^d5^d13; c3 = d2^d6^d14
  - c4 = d0^d1^d2^d7^d12^d13^d14
  - c5 = d0^d8^d12; c6 = d1^d9^d13; c7 = d2^d10^d14
  - c8 = d0^d1^d2^d11^d12^d13^d14
- States: IDLE, SHIFT, CHECK, HOLD. 25-bit shift register, 5-bit bit counter.
- IDLE: in_ready=1. A transfer with in_sof=1 loads the bit, sets count=1 and goes to SHIFT. A transfer with in_sof=0 is accepted and discarded.
- SHIFT: in_ready=1. Each transfer shifts the bit in and increments count. The transfer that makes count=25 moves to CHECK.
- A transfer with in_sof=1 in SHIFT restarts the frame: the partial frame is discarded, the bit is loaded, count=1, and the state stays SHIFT. No output and no error count.
- CHECK: one cycle, in_ready=0. Registers out_data, out_crc_rx, out_crc_calc and out_crc_err. Increments err_count if there is an error, saturating at 255. Goes to HOLD.
- HOLD: in_ready=0, out_valid=1. Outputs are stable until an output transfer, then the block returns to IDLE.
- in_valid while in_ready=0 is not a transfer; the sender holds its bit.

## Timing
- Reset (async assert, state takes effect immediately): state=IDLE, count=0, shift register=0, out_data=0, out_crc_rx=0, out_crc_calc=0, out_crc_err=0, out_valid=0, err_count=0, in_ready=1.
- Reset mid-frame or during HOLD discards the frame with no output.
- Latency: the edge accepting bit 25 enters CHECK. The next edge asserts out_valid. out_valid is first high 2 cycles after the last bit transfer.
- Back-to-back throughput: a minimum of 25 + 1 (CHECK) + 1 (HOLD with out_ready=1) = 27 cycles per frame.
- in_ready deasserts on the edge entering CHECK and reasserts on the edge leaving HOLD, so the new frame's SOF may be transferred in the first IDLE cycle.
- err_count changes only on the CHECK→HOLD edge and holds at 255 once saturated.

## Test plan
- Data 0x0001 with CRC 0x133 → out_data=0x0001, out_crc_calc=0x133, out_crc_err=0, err_count=0, out_valid 2 cycles after the last bit.
- Data 0xFFFF with CRC 0x1FE → no error. Data 0x0010 with CRC 0x003 → out_crc_calc=0x002, out_crc_err=1, err_count=1.
- Random in_valid gaps and out_ready held low 10 cycles:
  - in_ready=0 throughout CHECK/HOLD.
  - Outputs stable until the output transfer.
  - The next frame's SOF is accepted right after.
- in_sof after 10 bits of a frame, followed by a full 0x0000/0x000 frame → exactly one output: 0x0000, no error, err_count unchanged.
- rst asserted after 20 bits, then a clean frame → no spurious output; all outputs are at reset values during rst; the following frame decodes correctly.
- 260 consecutive bad-CRC frames → err_count reaches 255 and stays 255.
